// File: rtl/prom_boot_pkg.sv
// Shared types and constants for the PROM boot loader slice.
package prom_boot_pkg;

    localparam int unsigned PROM_ADDR_W = 5;
    localparam int unsigned PROM_DATA_W = 8;
    localparam int unsigned PROM_DEPTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Index width for a count of n items, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prom_boot_loader_if.sv
// Downstream word-write port: valid/ready handshake with address and data.
interface prom_boot_loader_if #(
    parameter int unsigned WA_W   = 3,
    parameter int unsigned WORD_W = 32
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [WA_W-1:0]   wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/prom_byte_fetch.sv
// One PROM access engine: holds CE_N low for WAIT_CYCLES and strobes the byte
// on the last cycle of each access.
module prom_byte_fetch
    import prom_boot_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   run_i,
    input  logic [PROM_DATA_W-1:0] prom_d_i,
    output logic                   prom_ce_n_o,
    output logic                   byte_stb_o,
    output logic [PROM_DATA_W-1:0] byte_o
);

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    logic       ce_n_q;
    logic [3:0] wait_q;
    logic [3:0] wait_d;

    assign prom_ce_n_o = ce_n_q;
    assign byte_stb_o  = !ce_n_q && (wait_q == LAST);
    assign byte_o      = prom_d_i;

    // Wait counter restarts at every new access (CE_N just dropped or byte taken).
    always_comb begin
        wait_d = wait_q + 4'd1;
        if (ce_n_q || byte_stb_o || !run_i) begin
            wait_d = '0;
        end
    end

    // Chip enable follows the loader's next state so it is low exactly in FETCH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ce_n_q <= 1'b1;
            wait_q <= '0;
        end else begin
            ce_n_q <= !run_i;
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/prom_boot_loader.sv
// Boot loader: reads NUM_BYTES from a 32x8 PROM, packs little-endian words,
// writes them downstream over valid/ready and keeps an 8-bit checksum.
module prom_boot_loader
    import prom_boot_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES    = 2,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned NUM_BYTES      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [PROM_ADDR_W-1:0] prom_a,
    output logic                   prom_ce_n,
    input  logic [PROM_DATA_W-1:0] prom_d,
    prom_boot_loader_if.master     wr,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             csum
);

    localparam int unsigned WORD_W    = 8 * BYTES_PER_WORD;
    localparam int unsigned NUM_WORDS = NUM_BYTES / BYTES_PER_WORD;
    localparam int unsigned WA_W      = idx_width(NUM_WORDS);
    localparam logic [2:0]  LANE_MASK = 3'(BYTES_PER_WORD - 1);
    localparam logic [WA_W-1:0] LAST_WORD = WA_W'(NUM_WORDS - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [5:0]             bcnt_q;
    logic [PROM_ADDR_W-1:0] prom_a_q;
    logic                   wr_valid_q;
    logic [WA_W-1:0]        wr_addr_q;
    logic [WORD_W-1:0]      wr_data_q;
    logic                   busy_q;
    logic                   done_q;
    logic [7:0]             csum_q;

    logic                   run;
    logic                   byte_stb;
    logic [PROM_DATA_W-1:0] byte_val;
    logic [2:0]             lane;
    logic                   last_lane;
    logic                   accept;
    logic                   last_word;

    assign lane      = bcnt_q[2:0] & LANE_MASK;
    assign last_lane = (lane == LANE_MASK);
    assign accept    = wr_valid_q && wr.wr_ready;
    assign last_word = (wr_addr_q == LAST_WORD);

    assign prom_a      = prom_a_q;
    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign csum        = csum_q;

    // Next-state decode; the fetch engine and status flags are driven from it
    // so that they are registered yet change on the same edge as the state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start)                  state_d = ST_FETCH;
            ST_FETCH:         if (byte_stb && last_lane)  state_d = ST_WRITE;
            ST_WRITE:         if (accept)                 state_d = last_word ? ST_DONE : ST_FETCH;
            default:                                      state_d = ST_IDLE;
        endcase
    end

    assign run = (state_d == ST_FETCH);

    prom_byte_fetch #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_fetch (
        .clk_i       (clk),
        .rst_i       (reset),
        .run_i       (run),
        .prom_d_i    (prom_d),
        .prom_ce_n_o (prom_ce_n),
        .byte_stb_o  (byte_stb),
        .byte_o      (byte_val)
    );

    // Sequencer state, counters, lane packer and checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bcnt_q     <= '0;
            prom_a_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_valid_q <= (state_d == ST_WRITE);
            busy_q     <= (state_d == ST_FETCH) || (state_d == ST_WRITE);
            done_q     <= (state_d == ST_DONE);
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        bcnt_q    <= '0;
                        wr_addr_q <= '0;
                        csum_q    <= '0;
                        prom_a_q  <= '0;
                    end
                end
                ST_FETCH: begin
                    if (byte_stb) begin
                        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                            if (lane == 3'(i)) begin
                                wr_data_q[i*8 +: 8] <= byte_val;
                            end
                        end
                        csum_q <= csum_q + byte_val;
                        bcnt_q <= bcnt_q + 6'd1;
                        // Address advances now only if the word is not yet full;
                        // otherwise it is held through WRITE and advanced on accept.
                        if (!last_lane) begin
                            prom_a_q <= PROM_ADDR_W'(bcnt_q + 6'd1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (accept) begin
                        wr_addr_q <= wr_addr_q + WA_W'(1);
                        if (!last_word) begin
                            prom_a_q <= bcnt_q[PROM_ADDR_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prom_boot_loader.sv
// Scoreboard bench for prom_boot_loader: three instances cover the default
// configuration, WAIT_CYCLES=3 and BYTES_PER_WORD=1.
module tb_prom_boot_loader;

    typedef struct {
        int unsigned addr;
        logic [63:0] data;
    } exp_t;

    int tests = 0;
    int fails = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [4:0] a0, a1, a2;
    logic ce_n0, ce_n1, ce_n2;
    logic [7:0] d0, d2;
    logic [7:0] d1 = 8'h00;
    logic busy0, busy1, busy2, done0, done1, done2;
    logic [7:0] csum0, csum1, csum2;

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;

    always #5 clk = ~clk;

    assign d0 = {3'b000, a0};
    assign d2 = 8'hFF;

    prom_boot_loader_if #(.WA_W(3), .WORD_W(32)) w0 ();
    prom_boot_loader_if #(.WA_W(3), .WORD_W(32)) w1 ();
    prom_boot_loader_if #(.WA_W(5), .WORD_W(8))  w2 ();

    prom_boot_loader dut0 (
        .clk(clk), .reset(reset), .start(start0), .prom_a(a0), .prom_ce_n(ce_n0),
        .prom_d(d0), .wr(w0), .busy(busy0), .done(done0), .csum(csum0)
    );
    prom_boot_loader #(.WAIT_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .prom_a(a1), .prom_ce_n(ce_n1),
        .prom_d(d1), .wr(w1), .busy(busy1), .done(done1), .csum(csum1)
    );
    prom_boot_loader #(.BYTES_PER_WORD(1), .NUM_BYTES(32)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .prom_a(a2), .prom_ce_n(ce_n2),
        .prom_d(d2), .wr(w2), .busy(busy2), .done(done2), .csum(csum2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic dn(input int which);
        case (which)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // Counts edges after the start-sampling edge until done; -1 on timeout.
    task automatic wait_done(input int which, input int limit, output int cycles);
        cycles = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (dn(which)) return;
        end
        cycles = -1;
    endtask

    // Returns at edge0 + 1, i.e. just after the edge that sampled start.
    task automatic do_start(input int which);
        @(posedge clk); #1;
        case (which)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    // d = a, four bytes per word, little-endian.
    task automatic push_words0();
        for (int w = 0; w < 8; w++) begin
            e0.addr = w;
            e0.data = 64'(32'h03020100 + 32'(w) * 32'h04040404);
            q0.push_back(e0);
        end
    endtask

    // Monitor for dut0: pops on acceptance, checks stability during stalls.
    always @(negedge clk) begin
        if (!reset && w0.wr_valid) begin
            check("ce_n_high_in_write0", 64'(ce_n0), 64'd1);
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write0: got addr %0d, expected no write", w0.wr_addr);
            end else if (w0.wr_ready) begin
                e0 = q0.pop_front();
                check("wr_addr0", 64'(w0.wr_addr), 64'(e0.addr));
                check("wr_data0", 64'(w0.wr_data), e0.data);
            end else begin
                check("stall_addr0", 64'(w0.wr_addr), 64'(q0[0].addr));
                check("stall_data0", 64'(w0.wr_data), q0[0].data);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && w1.wr_valid && w1.wr_ready) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write1: got addr %0d, expected no write", w1.wr_addr);
            end else begin
                e1 = q1.pop_front();
                check("wr_addr1", 64'(w1.wr_addr), 64'(e1.addr));
                check("wr_data1", 64'(w1.wr_data), e1.data);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && w2.wr_valid && w2.wr_ready) begin
            if (q2.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write2: got addr %0d, expected no write", w2.wr_addr);
            end else begin
                e2 = q2.pop_front();
                check("wr_addr2", 64'(w2.wr_addr), 64'(e2.addr));
                check("wr_data2", 64'(w2.wr_data), e2.data);
            end
        end
    end

    // dut1 PROM model: tracks each access, checks it lasts three stable cycles
    // with CE_N low, and presents garbage except in the final cycle.
    logic [4:0] last_a1 = 5'd0;
    bit act1 = 1'b0;
    int acc1 = 0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            act1 = 1'b0;
            acc1 = 0;
        end else if (!ce_n1) begin
            if (act1 && a1 == last_a1) begin
                acc1++;
            end else begin
                if (act1) check("access_len1", 64'(acc1), 64'd2);
                acc1 = 0;
            end
            act1 = 1'b1;
            last_a1 = a1;
        end else begin
            if (act1) check("access_len1", 64'(acc1), 64'd2);
            act1 = 1'b0;
        end
        d1 = (!ce_n1 && acc1 == 2) ? {3'b000, a1} : ({3'b000, a1} ^ 8'h5A);
    end

    initial begin
        int cyc;
        bit found;
        w0.wr_ready = 1'b1;
        w1.wr_ready = 1'b1;
        w2.wr_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_prom_a", 64'(a0), 64'd0);
        check("rst_ce_n", 64'(ce_n0), 64'd1);
        check("rst_wr_valid", 64'(w0.wr_valid), 64'd0);
        check("rst_wr_addr", 64'(w0.wr_addr), 64'd0);
        check("rst_wr_data", 64'(w0.wr_data), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_csum", 64'(csum0), 64'd0);
        reset = 1'b0;

        // Plain load: 32*2 + 8 cycles.
        push_words0();
        do_start(0);
        check("busy_after_start", 64'(busy0), 64'd1);
        check("ce_n_after_start", 64'(ce_n0), 64'd0);
        wait_done(0, 300, cyc);
        check("latency_plain", 64'(cyc), 64'(32 * 2 + 8));
        check("csum_plain", 64'(csum0), 64'hF0);
        check("busy_in_done", 64'(busy0), 64'd0);
        check("ce_n_in_done", 64'(ce_n0), 64'd1);
        check("prom_a_hold", 64'(a0), 64'd31);
        check("sb_empty_plain", 64'(q0.size()), 64'd0);

        // Restart from DONE, with a 5-cycle stall on word 3.
        push_words0();
        do_start(0);
        check("restart_done_clr", 64'(done0), 64'd0);
        check("restart_csum_clr", 64'(csum0), 64'd0);
        check("restart_prom_a", 64'(a0), 64'd0);
        fork
            wait_done(0, 300, cyc);
            begin
                found = 1'b0;
                for (int i = 0; i < 200 && !found; i++) begin
                    @(posedge clk); #1;
                    if (w0.wr_valid && w0.wr_addr == 3'd3) found = 1'b1;
                end
                check("bp_word3_seen", 64'(found), 64'd1);
                if (found) begin
                    w0.wr_ready = 1'b0;
                    repeat (5) @(posedge clk);
                    #1;
                    w0.wr_ready = 1'b1;
                end
            end
        join
        check("latency_stall", 64'(cyc), 64'(32 * 2 + 8 + 5));
        check("csum_stall", 64'(csum0), 64'hF0);
        check("sb_empty_stall", 64'(q0.size()), 64'd0);

        // start pulse during FETCH must be ignored.
        push_words0();
        do_start(0);
        fork
            wait_done(0, 300, cyc);
            begin
                repeat (10) @(posedge clk);
                #1;
                start0 = 1'b1;
                @(posedge clk); #1;
                start0 = 1'b0;
            end
        join
        check("latency_start_in_fetch", 64'(cyc), 64'(32 * 2 + 8));
        check("csum_start_in_fetch", 64'(csum0), 64'hF0);
        check("sb_empty_start_in_fetch", 64'(q0.size()), 64'd0);

        // Reset while word 2 is offered.
        push_words0();
        do_start(0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (w0.wr_valid && w0.wr_addr == 3'd2) found = 1'b1;
        end
        check("rst_word2_seen", 64'(found), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_wr_valid", 64'(w0.wr_valid), 64'd0);
        check("midrst_wr_addr", 64'(w0.wr_addr), 64'd0);
        check("midrst_wr_data", 64'(w0.wr_data), 64'd0);
        check("midrst_ce_n", 64'(ce_n0), 64'd1);
        check("midrst_prom_a", 64'(a0), 64'd0);
        check("midrst_busy", 64'(busy0), 64'd0);
        check("midrst_csum", 64'(csum0), 64'd0);
        q0.delete();
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", 64'(done0), 64'd0);
        reset = 1'b0;
        push_words0();
        do_start(0);
        wait_done(0, 300, cyc);
        check("latency_after_rst", 64'(cyc), 64'(32 * 2 + 8));
        check("csum_after_rst", 64'(csum0), 64'hF0);
        check("sb_empty_after_rst", 64'(q0.size()), 64'd0);

        // WAIT_CYCLES = 3 instance.
        for (int w = 0; w < 8; w++) begin
            e1.addr = w;
            e1.data = 64'(32'h03020100 + 32'(w) * 32'h04040404);
            q1.push_back(e1);
        end
        do_start(1);
        wait_done(1, 400, cyc);
        check("latency_wait3", 64'(cyc), 64'(32 * 3 + 8));
        check("csum_wait3", 64'(csum1), 64'hF0);
        check("sb_empty_wait3", 64'(q1.size()), 64'd0);

        // One byte per word, PROM returns 0xFF.
        for (int i = 0; i < 32; i++) begin
            e2.addr = i;
            e2.data = 64'hFF;
            q2.push_back(e2);
        end
        do_start(2);
        wait_done(2, 400, cyc);
        check("latency_bpw1", 64'(cyc), 64'(32 * 2 + 32));
        check("csum_bpw1", 64'(csum2), 64'hE0);
        check("sb_empty_bpw1", 64'(q2.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
